// File: rtl/sipo_frame_deserializer.sv
// sipo_frame_deserializer
//   Serial-to-parallel frame collector for the triangle-data input path.
//   Assembles FRAME_BITS qualified serial bits into a frame and hands it off
//   through a valid/ready holding register. The next frame keeps assembling
//   while the held frame waits. A frame that completes while the holding
//   register is still occupied is dropped and flagged.
//
//   Optional feature macro: PARITY_CHECK_EN
//     defined   : each frame carries one trailing even-parity bit (not stored);
//                 parity_err is registered alongside frame_out.
//     undefined : no parity bit; parity_err is tied to 0.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   bit_in       in   serial data bit
//   bit_valid    in   qualifies bit_in
//   frame_sync   in   synchronous restart, discards the partial frame
//   frame_out    out  held frame (FRAME_BITS)
//   frame_valid  out  frame_out holds an unconsumed frame
//   frame_ready  in   consumer accepts when frame_valid && frame_ready
//   frame_done   out  1-cycle pulse when a frame is loaded into frame_out
//   overrun      out  1-cycle pulse when a completed frame is dropped
//   bit_count    out  bits collected in the current partial frame (CNT_W)
//   parity_err   out  parity status of frame_out
module sipo_frame_deserializer #(
    parameter int unsigned FRAME_BITS = 144,
    parameter bit          LSB_FIRST  = 1'b1,
    parameter int unsigned CNT_W      = $clog2(FRAME_BITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  frame_sync,
    output logic [FRAME_BITS-1:0] frame_out,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_done,
    output logic                  overrun,
    output logic [CNT_W-1:0]      bit_count,
    output logic                  parity_err
);

`ifdef PARITY_CHECK_EN
    // The parity bit is the completing bit, one position past the data.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS);
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);
`endif

    logic [FRAME_BITS-1:0] shifter;
    logic [FRAME_BITS-1:0] shifted_c;
    logic [FRAME_BITS-1:0] frame_c;
    logic                  complete_c;
    logic                  accept_c;
    logic                  free_c;
`ifdef PARITY_CHECK_EN
    logic                  parity_c;
    logic                  parity_q;
`endif

    // Next shifter value, completion detect and holding-register availability.
    always_comb begin
        shifted_c  = shifter;
        if (LSB_FIRST) begin
            shifted_c = {bit_in, shifter[FRAME_BITS-1:1]};
        end else begin
            shifted_c = {shifter[FRAME_BITS-2:0], bit_in};
        end
        complete_c = bit_valid && !frame_sync && (bit_count == LAST_IDX);
        accept_c   = frame_valid && frame_ready;
        free_c     = !frame_valid || accept_c;
`ifdef PARITY_CHECK_EN
        // Data is already complete in the shifter; the incoming bit is parity.
        frame_c    = shifter;
        parity_c   = (^shifter) ^ bit_in;
`else
        // The completing bit is part of the frame.
        frame_c    = shifted_c;
`endif
    end

    // Shifter and bit counter; wraps to 0 on the completing bit so frames abut.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter   <= '0;
            bit_count <= '0;
        end else if (frame_sync) begin
            shifter   <= '0;
            bit_count <= '0;
        end else if (bit_valid) begin
            if (complete_c) begin
                shifter   <= '0;
                bit_count <= '0;
            end else begin
                shifter   <= shifted_c;
                bit_count <= bit_count + CNT_W'(1);
            end
        end
    end

    // Holding register with valid/ready handoff and overrun detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_out   <= '0;
            frame_valid <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            if (complete_c && free_c) begin
                frame_out   <= frame_c;
                frame_valid <= 1'b1;
                frame_done  <= 1'b1;
`ifdef PARITY_CHECK_EN
                parity_q    <= parity_c;
`endif
            end else begin
                if (complete_c) begin
                    overrun <= 1'b1;
                end
                if (accept_c) begin
                    frame_valid <= 1'b0;
                end
            end
        end
    end

`ifdef PARITY_CHECK_EN
    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_deserializer.sv
// Testbench for sipo_frame_deserializer: two instances (LSB-first and
// MSB-first, FRAME_BITS=8) share one stimulus stream and are checked against
// a bit-list reference model of frame assembly and the valid/ready handoff.
module tb_sipo_frame_deserializer;

    localparam int FB = 8;
`ifdef PARITY_CHECK_EN
    localparam int NB = FB + 1;
`else
    localparam int NB = FB;
`endif
    localparam int CW = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          frame_sync = 1'b0;
    logic          frame_ready = 1'b0;
    logic [FB-1:0] fo_l, fo_m;
    logic          fv_l, fv_m, fd_l, fd_m, ov_l, ov_m, pe_l, pe_m;
    logic [CW-1:0] bc_l, bc_m;

    always #5 clk = ~clk;

    sipo_frame_deserializer #(.FRAME_BITS(FB), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_sync(frame_sync), .frame_out(fo_l), .frame_valid(fv_l),
        .frame_ready(frame_ready), .frame_done(fd_l), .overrun(ov_l),
        .bit_count(bc_l), .parity_err(pe_l));

    sipo_frame_deserializer #(.FRAME_BITS(FB), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .frame_sync(frame_sync), .frame_out(fo_m), .frame_valid(fv_m),
        .frame_ready(frame_ready), .frame_done(fd_m), .overrun(ov_m),
        .bit_count(bc_m), .parity_err(pe_m));

    int total = 0;
    int bad   = 0;

    // Reference model: list of received bits plus the held frame.
    int            mcount;
    bit            mpart[NB];
    logic [FB-1:0] exp_l, exp_m;
    logic          exp_valid, exp_done, exp_ovr, exp_perr;
    int            o_done_l = 0, o_ovr_l = 0, o_done_m = 0, o_ovr_m = 0;

    task automatic model_reset();
        mcount = 0; exp_l = '0; exp_m = '0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic step(input logic bv, input logic b, input logic sync, input logic rdy);
        logic acc, loaded;
        int   ones;
        bit_valid = bv; bit_in = b; frame_sync = sync; frame_ready = rdy;
        @(posedge clk);
        acc = exp_valid && rdy;
        loaded = 1'b0; exp_done = 1'b0; exp_ovr = 1'b0;
        if (sync) begin
            mcount = 0;
        end else if (bv) begin
            mpart[mcount] = b;
            mcount++;
            if (mcount == NB) begin
                mcount = 0;
                if (!exp_valid || acc) begin
                    ones = 0;
                    for (int i = 0; i < NB; i++) ones += int'(mpart[i]);
                    for (int i = 0; i < FB; i++) begin
                        exp_l[i]        = mpart[i];
                        exp_m[FB-1-i]   = mpart[i];
                    end
                    exp_perr  = (NB > FB) && ((ones % 2) == 1);
                    exp_valid = 1'b1; exp_done = 1'b1; loaded = 1'b1;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
        if (acc && !loaded) exp_valid = 1'b0;
        #1;
        o_done_l += int'(fd_l); o_ovr_l += int'(ov_l);
        o_done_m += int'(fd_m); o_ovr_m += int'(ov_m);
    endtask

    // Stream d[0]..d[FB-1], then (parity build) even parity optionally inverted.
    task automatic send_frame(input logic [FB-1:0] d, input logic rdy_body,
                              input logic rdy_last, input logic pflip);
        logic b;
        for (int i = 0; i < NB; i++) begin
            if (i < FB) b = d[i];
            else        b = (^d) ^ pflip;
            step(1'b1, b, 1'b0, (i == NB - 1) ? rdy_last : rdy_body);
        end
    endtask

    task automatic idle_clear();
        step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        total++;
        if ({fo_l, fv_l, fd_l, ov_l, bc_l, pe_l} !== '0) begin
            bad++; $display("FAIL reset_lsb got=%h want=0", {fo_l, fv_l, fd_l, ov_l, bc_l, pe_l});
        end
        total++;
        if ({fo_m, fv_m, fd_m, ov_m, bc_m, pe_m} !== '0) begin
            bad++; $display("FAIL reset_msb got=%h want=0", {fo_m, fv_m, fd_m, ov_m, bc_m, pe_m});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int d0;
        idle_clear();
        d0 = o_done_l;
        send_frame(8'h4D, 1'b1, 1'b1, 1'b0);
        total++;
        if (fo_l !== 8'h4D) begin bad++; $display("FAIL basic_lsb got=%h want=4d", fo_l); end
        total++;
        if (fo_m !== 8'hB2) begin bad++; $display("FAIL basic_msb got=%h want=b2", fo_m); end
        total++;
        if ({fv_l, fd_l, fv_m, fd_m} !== 4'b1111) begin
            bad++; $display("FAIL basic_valid_done got=%b want=1111", {fv_l, fd_l, fv_m, fd_m});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if ({fv_l, fd_l, fv_m, fd_m} !== 4'b0000) begin
            bad++; $display("FAIL basic_after got=%b want=0000", {fv_l, fd_l, fv_m, fd_m});
        end
        total++;
        if (o_done_l - d0 !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", o_done_l - d0); end
    endtask

    task automatic test_gaps();
        logic [FB-1:0] d;
        logic          b;
        d = 8'h4D;
        idle_clear();
        for (int i = 0; i < NB; i++) begin
            if (i < FB) b = d[i];
            else        b = ^d;
            step(1'b1, b, 1'b0, 1'b1);
            if (i == NB - 1) begin
                total++;
                if (fo_l !== 8'h4D || fo_m !== 8'hB2) begin
                    bad++; $display("FAIL gaps_frame got=%h/%h want=4d/b2", fo_l, fo_m);
                end
            end
            step(1'b0, 1'($urandom), 1'b0, 1'b1);
            total++;
            if (bc_l !== CW'((i + 1) % NB) || bc_m !== CW'((i + 1) % NB)) begin
                bad++; $display("FAIL gaps_count got=%0d/%0d want=%0d", bc_l, bc_m, (i + 1) % NB);
            end
        end
    endtask

    task automatic test_overrun();
        logic [FB-1:0] d1, d2;
        int dn, ovn;
        d1 = FB'($urandom); d2 = FB'($urandom);
        idle_clear();
        dn = o_done_l; ovn = o_ovr_l;
        send_frame(d1, 1'b0, 1'b0, 1'b0);
        send_frame(d2, 1'b0, 1'b0, 1'b0);
        total++;
        if (fo_l !== d1) begin bad++; $display("FAIL ovr_held got=%h want=%h", fo_l, d1); end
        total++;
        if (fo_m !== exp_m) begin bad++; $display("FAIL ovr_held_msb got=%h want=%h", fo_m, exp_m); end
        total++;
        if (o_ovr_l - ovn !== 1 || o_done_l - dn !== 1) begin
            bad++; $display("FAIL ovr_pulses got ovr=%0d done=%0d want 1/1", o_ovr_l - ovn, o_done_l - dn);
        end
        total++;
        if (fv_l !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", fv_l); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        total++;
        if (fv_l !== 1'b0 || fv_m !== 1'b0) begin bad++; $display("FAIL ovr_release got=%b%b want=00", fv_l, fv_m); end
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] d1, d2;
        int ovn;
        d1 = FB'($urandom); d2 = ~d1;
        idle_clear();
        ovn = o_ovr_l;
        send_frame(d1, 1'b0, 1'b0, 1'b0);
        send_frame(d2, 1'b0, 1'b1, 1'b0);
        total++;
        if (o_ovr_l - ovn !== 0) begin bad++; $display("FAIL b2b_overrun got=%0d want=0", o_ovr_l - ovn); end
        total++;
        if (fo_l !== d2) begin bad++; $display("FAIL b2b_frame got=%h want=%h", fo_l, d2); end
        total++;
        if ({fv_l, fd_l} !== 2'b11) begin bad++; $display("FAIL b2b_valid got=%b want=11", {fv_l, fd_l}); end
    endtask

    task automatic test_sync_and_reset();
        logic [FB-1:0] d;
        idle_clear();
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        total++;
        if (bc_l !== '0) begin bad++; $display("FAIL sync_count got=%0d want=0", bc_l); end
        d = FB'($urandom);
        send_frame(d, 1'b1, 1'b1, 1'b0);
        total++;
        if (fo_l !== d) begin bad++; $display("FAIL sync_frame got=%h want=%h", fo_l, d); end
        total++;
        if (fo_m !== exp_m) begin bad++; $display("FAIL sync_frame_msb got=%h want=%h", fo_m, exp_m); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
        total++;
        if (bc_l !== CW'(3)) begin bad++; $display("FAIL pre_rst_count got=%0d want=3", bc_l); end
        #2 rst = 1'b1;
        #1;
        model_reset();
        total++;
        if ({fo_l, fv_l, fd_l, ov_l, bc_l, pe_l, fo_m, fv_m, bc_m} !== '0) begin
            bad++; $display("FAIL async_rst got=%h want=0", {fo_l, fv_l, fd_l, ov_l, bc_l, pe_l, fo_m, fv_m, bc_m});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic bv, b, sy, rdy;
        idle_clear();
        for (int n = 0; n < 400; n++) begin
            bv  = ($urandom % 4) != 0;
            b   = 1'($urandom);
            sy  = ($urandom % 40) == 0;
            rdy = ($urandom % 3) == 0;
            step(bv, b, sy, rdy);
            total++;
            if (fo_l !== exp_l || fo_m !== exp_m) begin
                bad++; $display("FAIL rnd_frame cyc=%0d got=%h/%h want=%h/%h", n, fo_l, fo_m, exp_l, exp_m);
            end
            total++;
            if ({fv_l, fd_l, ov_l, pe_l} !== {exp_valid, exp_done, exp_ovr, exp_perr} ||
                {fv_m, fd_m, ov_m, pe_m} !== {exp_valid, exp_done, exp_ovr, exp_perr}) begin
                bad++; $display("FAIL rnd_flags cyc=%0d got=%b/%b want=%b", n, {fv_l, fd_l, ov_l, pe_l},
                                {fv_m, fd_m, ov_m, pe_m}, {exp_valid, exp_done, exp_ovr, exp_perr});
            end
            total++;
            if (bc_l !== CW'(mcount) || bc_m !== CW'(mcount)) begin
                bad++; $display("FAIL rnd_count cyc=%0d got=%0d/%0d want=%0d", n, bc_l, bc_m, mcount);
            end
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        idle_clear();
        send_frame(8'h4D, 1'b1, 1'b1, 1'b0);
        total++;
        if (pe_l !== 1'b0 || fo_l !== 8'h4D) begin bad++; $display("FAIL parity_ok got=%b/%h want=0/4d", pe_l, fo_l); end
        send_frame(8'h4D, 1'b1, 1'b1, 1'b1);
        total++;
        if (pe_l !== 1'b1 || pe_m !== 1'b1) begin bad++; $display("FAIL parity_bad got=%b%b want=11", pe_l, pe_m); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_sync_and_reset();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
